interrupt_arbiter: RTL and testbench

Multi-source interrupt arbiter that sits in front of the pipeline's interrupt controller. It edge-detects up to N_SRC active-low peripheral request lines and latches them as pending. It selects one unmasked source by fixed priority and drives the controller's single active-low `interrupt_signal` with a request/accept/return handshake. It also supplies the ISR entry address and acknowledges the serviced source when the controller returns from the ISR.

---
 rtl/interrupt_arbiter.sv | 157 +++++++++++++++
 tb/tb_interrupt_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_arbiter.sv
// Fixed-priority interrupt arbiter: edge-detects active-low requests, latches them as pending,
// and runs a request/accept/return handshake with the pipeline's interrupt controller.
module interrupt_arbiter #(
   parameter int unsigned N_SRC      = 4,
   parameter logic [11:0] ISR_BASE   = 12'h800,
   parameter logic [11:0] ISR_STRIDE = 12'h040,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [N_SRC-1:0] irq_n,
   input  logic [N_SRC-1:0] irq_mask,
   input  logic             sel_ISR,
   input  logic             ret_ISR,
   output logic             interrupt_signal,
   output logic [11:0]      isr_addr,
   output logic [2:0]       irq_id,
   output logic [N_SRC-1:0] irq_ack,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] lost,
   output logic             timeout_err,
   output logic             busy
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StReq, StService, StDone} state_e;

   state_e           state_q, state_d;
   logic [N_SRC-1:0] irq_n_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] lost_q, lost_d;
   logic [N_SRC-1:0] ack_q, ack_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             int_q, int_d;
   logic [11:0]      addr_q, addr_d;
   logic [2:0]       id_q, id_d;
   logic             terr_q, terr_d;

   logic [N_SRC-1:0] edge_det;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] winner_oh;
   logic [N_SRC-1:0] id_oh;
   logic [N_SRC-1:0] grant_clr;
   logic [N_SRC-1:0] requeue;
   logic [2:0]       winner;

   always_comb begin
      edge_det  = irq_n_q & ~irq_n;
      eligible  = pending_q & ~irq_mask;
      winner    = 3'd0;
      winner_oh = '0;
      // Descending scan so the lowest eligible index is the one left standing.
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner    = 3'(i);
            winner_oh = '0;
            winner_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < int'(N_SRC); i++) begin
         id_oh[i] = (id_q == 3'(i));
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      int_d     = int_q;
      addr_d    = addr_q;
      id_d      = id_q;
      ack_d     = '0;
      terr_d    = terr_q;
      grant_clr = '0;
      requeue   = '0;

      unique case (state_q)
         StIdle: begin
            if (|eligible) begin
               state_d   = StReq;
               id_d      = winner;
               addr_d    = ISR_BASE + ({9'd0, winner} * ISR_STRIDE);
               grant_clr = winner_oh;
               int_d     = 1'b0;
               cnt_d     = '0;
            end
         end
         StReq: begin
            if (sel_ISR) begin
               state_d = StService;
               int_d   = 1'b1;
            end else if (cnt_q == CntMax) begin
               // Controller never accepted: drop the request and put the source back in line.
               state_d = StIdle;
               int_d   = 1'b1;
               requeue = id_oh;
               terr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StService: begin
            if (ret_ISR) begin
               state_d = StDone;
               ack_d   = id_oh;
            end
         end
         StDone: begin
            if (!sel_ISR) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A same-cycle edge beats the grant clear and is not counted as lost.
      pending_d = (pending_q & ~grant_clr) | requeue | edge_det;
      lost_d    = lost_q | (edge_det & pending_q & ~grant_clr);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q   <= StIdle;
         irq_n_q   <= '1;
         pending_q <= '0;
         lost_q    <= '0;
         ack_q     <= '0;
         cnt_q     <= '0;
         int_q     <= 1'b1;
         addr_q    <= ISR_BASE;
         id_q      <= 3'd0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         irq_n_q   <= irq_n;
         pending_q <= pending_d;
         lost_q    <= lost_d;
         ack_q     <= ack_d;
         cnt_q     <= cnt_d;
         int_q     <= int_d;
         addr_q    <= addr_d;
         id_q      <= id_d;
         terr_q    <= terr_d;
      end
   end

   assign interrupt_signal = int_q;
   assign isr_addr         = addr_q;
   assign irq_id           = id_q;
   assign irq_ack          = ack_q;
   assign pending          = pending_q;
   assign lost             = lost_q;
   assign timeout_err      = terr_q;
   assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: directed scenarios plus a randomized run against
// a queue-level model of pending/lost bookkeeping and fixed-priority service order.
module tb_interrupt_arbiter;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [3:0]  irq_n = 4'hF;
   logic [3:0]  irq_mask = 4'h0;
   logic        sel_ISR = 1'b0;
   logic        ret_ISR = 1'b0;
   logic        interrupt_signal;
   logic [11:0] isr_addr;
   logic [2:0]  irq_id;
   logic [3:0]  irq_ack;
   logic [3:0]  pending;
   logic [3:0]  lost;
   logic        timeout_err;
   logic        busy;

   int checks = 0;
   int failures = 0;

   interrupt_arbiter #(
      .N_SRC     (4),
      .ISR_BASE  (12'h800),
      .ISR_STRIDE(12'h040),
      .TIMEOUT   (16)
   ) dut (
      .clk             (clk),
      .nrst            (nrst),
      .irq_n           (irq_n),
      .irq_mask        (irq_mask),
      .sel_ISR         (sel_ISR),
      .ret_ISR         (ret_ISR),
      .interrupt_signal(interrupt_signal),
      .isr_addr        (isr_addr),
      .irq_id          (irq_id),
      .irq_ack         (irq_ack),
      .pending         (pending),
      .lost            (lost),
      .timeout_err     (timeout_err),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick;
      @(negedge clk);
   endtask

   task automatic apply_reset;
      nrst = 1'b0; irq_n = 4'hF; irq_mask = 4'h0; sel_ISR = 1'b0; ret_ISR = 1'b0;
      tick; tick;
      nrst = 1'b1;
   endtask

   task automatic test_reset;
      apply_reset;
      checks++;
      if ({interrupt_signal, isr_addr, irq_id} !== {1'b1, 12'h800, 3'd0}) begin
         failures++;
         $display("FAIL reset_req: got sig=%b addr=%h id=%0d want sig=1 addr=800 id=0",
                  interrupt_signal, isr_addr, irq_id);
      end
      checks++;
      if ({irq_ack, pending, lost, timeout_err, busy} !== 14'd0) begin
         failures++;
         $display("FAIL reset_status: got ack=%b pend=%b lost=%b terr=%b busy=%b want zeros",
                  irq_ack, pending, lost, timeout_err, busy);
      end
   endtask

   task automatic test_single;
      apply_reset;
      irq_n = 4'b1011; tick; irq_n = 4'hF;
      checks++;
      if (pending !== 4'b0100 || interrupt_signal !== 1'b1) begin
         failures++;
         $display("FAIL single_pending: got pend=%b sig=%b want pend=0100 sig=1",
                  pending, interrupt_signal);
      end
      tick;
      checks++;
      if ({interrupt_signal, isr_addr, irq_id, pending} !== {1'b0, 12'h880, 3'd2, 4'b0000}) begin
         failures++;
         $display("FAIL single_grant: got sig=%b addr=%h id=%0d pend=%b want 0 880 2 0000",
                  interrupt_signal, isr_addr, irq_id, pending);
      end
      sel_ISR = 1'b1; tick;
      checks++;
      if (interrupt_signal !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_accept: got sig=%b busy=%b want 1 1", interrupt_signal, busy);
      end
      ret_ISR = 1'b1; tick; ret_ISR = 1'b0;
      checks++;
      if (irq_ack !== 4'b0100) begin
         failures++;
         $display("FAIL single_ack: got %b want 0100", irq_ack);
      end
      tick;
      checks++;
      if (irq_ack !== 4'b0000 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_ack_pulse: got ack=%b busy=%b want 0000 1", irq_ack, busy);
      end
      sel_ISR = 1'b0; tick;
      checks++;
      if (busy !== 1'b0 || pending !== 4'b0000) begin
         failures++;
         $display("FAIL single_idle: got busy=%b pend=%b want 0 0000", busy, pending);
      end
   endtask

   task automatic test_priority;
      apply_reset;
      irq_n = 4'b0101; tick; irq_n = 4'hF; tick;
      checks++;
      if ({irq_id, isr_addr, pending} !== {3'd1, 12'h840, 4'b1000}) begin
         failures++;
         $display("FAIL prio_first: got id=%0d addr=%h pend=%b want 1 840 1000",
                  irq_id, isr_addr, pending);
      end
      sel_ISR = 1'b1; tick;
      ret_ISR = 1'b1; tick; ret_ISR = 1'b0; sel_ISR = 1'b0;
      checks++;
      if (irq_ack !== 4'b0010) begin
         failures++;
         $display("FAIL prio_ack: got %b want 0010", irq_ack);
      end
      tick;
      checks++;
      if (busy !== 1'b0 || interrupt_signal !== 1'b1) begin
         failures++;
         $display("FAIL prio_gap: got busy=%b sig=%b want 0 1", busy, interrupt_signal);
      end
      tick;
      checks++;
      if ({interrupt_signal, irq_id, isr_addr, pending} !== {1'b0, 3'd3, 12'h8C0, 4'b0000}) begin
         failures++;
         $display("FAIL prio_second: got sig=%b id=%0d addr=%h pend=%b want 0 3 8c0 0000",
                  interrupt_signal, irq_id, isr_addr, pending);
      end
   endtask

   task automatic test_mask;
      apply_reset;
      irq_mask = 4'b0001;
      irq_n = 4'b1110; tick; irq_n = 4'hF;
      checks++;
      if (pending !== 4'b0001) begin
         failures++;
         $display("FAIL mask_pending: got %b want 0001", pending);
      end
      tick;
      checks++;
      if (interrupt_signal !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mask_hold: got sig=%b busy=%b want 1 0", interrupt_signal, busy);
      end
      irq_mask = 4'b0000; tick;
      checks++;
      if (interrupt_signal !== 1'b0 || irq_id !== 3'd0 || pending !== 4'b0000) begin
         failures++;
         $display("FAIL mask_release: got sig=%b id=%0d pend=%b want 0 0 0000",
                  interrupt_signal, irq_id, pending);
      end
   endtask

   task automatic test_timeout;
      int low;
      apply_reset;
      irq_n = 4'b1110; tick; irq_n = 4'hF; tick;
      low = 0;
      for (int t = 0; t < 40; t++) begin
         if (interrupt_signal !== 1'b0) break;
         low++;
         tick;
      end
      checks++;
      if (low != 16) begin
         failures++;
         $display("FAIL timeout_len: got %0d low cycles want 16", low);
      end
      checks++;
      if ({timeout_err, pending, busy, interrupt_signal} !== {1'b1, 4'b0001, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL timeout_state: got terr=%b pend=%b busy=%b sig=%b want 1 0001 0 1",
                  timeout_err, pending, busy, interrupt_signal);
      end
      tick;
      checks++;
      if (interrupt_signal !== 1'b0 || pending !== 4'b0000 || irq_id !== 3'd0) begin
         failures++;
         $display("FAIL timeout_regrant: got sig=%b pend=%b id=%0d want 0 0000 0",
                  interrupt_signal, pending, irq_id);
      end
   endtask

   task automatic test_lost;
      apply_reset;
      irq_mask = 4'b0010;
      irq_n = 4'b1101; tick; irq_n = 4'hF;
      checks++;
      if (pending !== 4'b0010 || lost !== 4'b0000) begin
         failures++;
         $display("FAIL lost_first: got pend=%b lost=%b want 0010 0000", pending, lost);
      end
      tick;
      irq_n = 4'b1101; tick; irq_n = 4'hF;
      checks++;
      if (lost !== 4'b0010) begin
         failures++;
         $display("FAIL lost_second: got %b want 0010", lost);
      end
      tick;
      irq_mask = 4'b0000; irq_n = 4'b1101; tick; irq_n = 4'hF;
      checks++;
      if ({interrupt_signal, irq_id, pending, lost} !== {1'b0, 3'd1, 4'b0010, 4'b0010}) begin
         failures++;
         $display("FAIL lost_coincide: got sig=%b id=%0d pend=%b lost=%b want 0 1 0010 0010",
                  interrupt_signal, irq_id, pending, lost);
      end
      // Same coincidence with lost still clear, so the set-wins rule is observable.
      apply_reset;
      irq_mask = 4'b0010;
      irq_n = 4'b1101; tick; irq_n = 4'hF; tick;
      irq_mask = 4'b0000; irq_n = 4'b1101; tick; irq_n = 4'hF;
      checks++;
      if ({interrupt_signal, irq_id, pending, lost} !== {1'b0, 3'd1, 4'b0010, 4'b0000}) begin
         failures++;
         $display("FAIL lost_setwins: got sig=%b id=%0d pend=%b lost=%b want 0 1 0010 0000",
                  interrupt_signal, irq_id, pending, lost);
      end
   endtask

   task automatic test_reset_mid;
      apply_reset;
      irq_n = 4'b1011; tick; irq_n = 4'hF; tick;
      sel_ISR = 1'b1; tick;
      irq_n = 4'b0111; tick; irq_n = 4'hF;
      checks++;
      if (pending !== 4'b1000 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_setup: got pend=%b busy=%b want 1000 1", pending, busy);
      end
      nrst = 1'b0; tick; nrst = 1'b1;
      checks++;
      if ({interrupt_signal, isr_addr, irq_id, irq_ack, pending, lost, timeout_err, busy} !==
          {1'b1, 12'h800, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL mid_reset: got sig=%b addr=%h id=%0d ack=%b pend=%b lost=%b terr=%b busy=%b",
                  interrupt_signal, isr_addr, irq_id, irq_ack, pending, lost, timeout_err, busy);
      end
      sel_ISR = 1'b0; tick;
      checks++;
      if (busy !== 1'b0 || pending !== 4'b0000 || interrupt_signal !== 1'b1) begin
         failures++;
         $display("FAIL mid_after: got busy=%b pend=%b sig=%b want 0 0000 1",
                  busy, pending, interrupt_signal);
      end
   endtask

   task automatic test_random;
      logic [3:0] m_pend;
      logic [3:0] m_lost;
      logic [3:0] set;
      logic [3:0] nmask;
      logic [3:0] elig;
      logic [3:0] oh;
      int         w;
      int         addr;
      int         d;
      apply_reset;
      m_pend = 4'h0;
      m_lost = 4'h0;
      for (int it = 0; it < 30; it++) begin
         set   = 4'($urandom_range(1, 15));
         nmask = 4'($urandom_range(0, 15));
         m_lost = m_lost | (set & m_pend);
         m_pend = m_pend | set;
         irq_n = ~set; tick; irq_n = 4'hF; irq_mask = nmask;
         elig = m_pend & ~nmask;
         while (elig != 4'h0) begin
            w = 0;
            while (elig[w] == 1'b0) w++;
            for (int t = 0; t < 8; t++) begin
               if (interrupt_signal === 1'b0) break;
               tick;
            end
            checks++;
            if (interrupt_signal !== 1'b0) begin
               failures++;
               $display("FAIL rnd_grant_wait: iter=%0d no grant, want source %0d", it, w);
               return;
            end
            m_pend[w] = 1'b0;
            addr = (2048 + w * 64) % 4096;
            checks++;
            if (irq_id !== 3'(w) || isr_addr !== 12'(addr) || pending !== m_pend) begin
               failures++;
               $display("FAIL rnd_grant: iter=%0d got id=%0d addr=%h pend=%b want %0d %h %b",
                        it, irq_id, isr_addr, pending, w, 12'(addr), m_pend);
            end
            d = $urandom_range(0, 5);
            repeat (d) tick;
            sel_ISR = 1'b1; tick;
            ret_ISR = 1'b1; tick; ret_ISR = 1'b0; sel_ISR = 1'b0;
            oh = 4'b0001 << w;
            checks++;
            if (irq_ack !== oh) begin
               failures++;
               $display("FAIL rnd_ack: iter=%0d got %b want %b", it, irq_ack, oh);
            end
            tick;
            elig = m_pend & ~nmask;
         end
         checks++;
         if ({busy, pending, lost, timeout_err} !== {1'b0, m_pend, m_lost, 1'b0}) begin
            failures++;
            $display("FAIL rnd_idle: iter=%0d got busy=%b pend=%b lost=%b terr=%b want 0 %b %b 0",
                     it, busy, pending, lost, timeout_err, m_pend, m_lost);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_priority;
      test_mask;
      test_timeout;
      test_lost;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
